// File: rtl/latch_loader_if.sv
// Serial-in / latch-bank-out bundle between a bit source and latch_loader.
interface latch_loader_if #(
  parameter int WIDTH = 8
);
  logic             sin;
  logic             sin_valid;
  logic             sin_ready;
  logic [WIDTH-1:0] d;
  logic             c;
  logic             busy;
  logic             done;

  modport master (
    output sin, sin_valid,
    input  sin_ready, d, c, busy, done
  );

  modport slave (
    input  sin, sin_valid,
    output sin_ready, d, c, busy, done
  );
endinterface

// File: rtl/latch_loader.sv
// Shifts serial bits MSB first into a word, then drives a setup/strobe/hold
// sequence on C so a downstream D-latch bank captures the word cleanly.
module latch_loader #(
  parameter int WIDTH      = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 1,
  parameter int HOLD_CYC   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  latch_loader_if.slave   bus
);

  localparam int CW   = $clog2(WIDTH + 1);
  localparam int MAXP = (SETUP_CYC > STROBE_CYC) ?
                        ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                        ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int PW   = (MAXP > 1) ? $clog2(MAXP) : 1;

  typedef enum logic [2:0] {IDLE, SHIFT, SETUP, STROBE, HOLD} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] d_q;
  logic [PW-1:0]    phase;
  logic             c_q;
  logic             done_q;

  logic             xfer;
  logic             last_bit;
  logic [WIDTH-1:0] shift_nx;

  assign bus.sin_ready = (state == IDLE) || (state == SHIFT);
  assign xfer          = bus.sin_valid && bus.sin_ready;
  assign last_bit      = (cnt == CW'(WIDTH - 1));
  // Truncating the concatenation keeps the low WIDTH bits, so WIDTH=1 needs no special case.
  assign shift_nx      = WIDTH'({shift_q, bus.sin});

  assign bus.d    = d_q;
  assign bus.c    = c_q;
  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      shift_q <= '0;
      d_q     <= '0;
      phase   <= '0;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, SHIFT: begin
          if (xfer) begin
            shift_q <= shift_nx;
            if (last_bit) begin
              d_q   <= shift_nx;
              cnt   <= '0;
              phase <= '0;
              state <= SETUP;
            end else begin
              cnt   <= cnt + CW'(1);
              state <= SHIFT;
            end
          end
        end
        SETUP: begin
          if (phase == PW'(SETUP_CYC - 1)) begin
            phase <= '0;
            c_q   <= 1'b1;
            state <= STROBE;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        STROBE: begin
          if (phase == PW'(STROBE_CYC - 1)) begin
            phase <= '0;
            c_q   <= 1'b0;
            state <= HOLD;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        HOLD: begin
          if (phase == PW'(HOLD_CYC - 1)) begin
            phase  <= '0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        default: begin
          state <= IDLE;
          c_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_loader.sv
// Randomised and directed bench for latch_loader, checked against a timeline model
// driven by the word-completion edge rather than by FSM states.
module tb_latch_loader;

  logic clk;
  logic rst_n;

  latch_loader_if #(.WIDTH(8)) b0 ();
  latch_loader_if #(.WIDTH(4)) b1 ();

  latch_loader #(.WIDTH(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave)
  );

  latch_loader #(.WIDTH(4), .SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t = 0;

  int          m_bits [2];
  int          m_e    [2];
  logic [31:0] m_acc  [2];
  logic [31:0] m_word [2];

  function automatic int pw(int k);  return (k == 0) ? 8 : 4; endfunction
  function automatic int ps(int k);  return (k == 0) ? 1 : 2; endfunction
  function automatic int pst(int k); return (k == 0) ? 1 : 3; endfunction
  function automatic int ph(int k);  return (k == 0) ? 1 : 2; endfunction
  function automatic int tot(int k); return ps(k) + pst(k) + ph(k); endfunction

  // Busy window after a completion: the edge it completes on up to the edge DONE rises.
  function automatic bit in_window(int k, int tt);
    return (tt >= m_e[k]) && (tt < m_e[k] + tot(k));
  endfunction

  function automatic void model_reset(int k);
    m_bits[k] = 0;
    m_e[k]    = -1000;
    m_acc[k]  = '0;
    m_word[k] = '0;
  endfunction

  function automatic void model_edge(int k, bit v, bit b);
    logic [31:0] mask;
    mask = (32'd1 << pw(k)) - 32'd1;
    if (v && !in_window(k, t - 1)) begin
      m_acc[k]  = ((m_acc[k] << 1) | {31'd0, b}) & mask;
      m_bits[k] = m_bits[k] + 1;
      if (m_bits[k] == pw(k)) begin
        m_word[k] = m_acc[k];
        m_bits[k] = 0;
        m_e[k]    = t;
      end
    end
  endfunction

  function automatic logic [35:0] expv(int k);
    bit rdy, cc, dn, bsy;
    rdy = !in_window(k, t);
    cc  = (t >= m_e[k] + ps(k)) && (t < m_e[k] + ps(k) + pst(k));
    dn  = (t == m_e[k] + tot(k));
    bsy = !rdy || (m_bits[k] > 0);
    return {m_word[k], cc, dn, bsy, rdy};
  endfunction

  function automatic logic [35:0] obs(int k);
    if (k == 0) return {24'd0, b0.d, b0.c, b0.done, b0.busy, b0.sin_ready};
    return {28'd0, b1.d, b1.c, b1.done, b1.busy, b1.sin_ready};
  endfunction

  task automatic step(input bit v0, input bit s0, input bit v1, input bit s1);
    @(negedge clk);
    b0.sin_valid = v0; b0.sin = s0;
    b1.sin_valid = v1; b1.sin = s1;
    @(posedge clk);
    t = t + 1;
    if (rst_n) begin
      model_edge(0, v0, s0);
      model_edge(1, v1, s1);
    end
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== {36'd0} + 36'd1) begin
        errors++;
        $display("[TB] FAIL reset_init dut%0d got %h expected %h", k, obs(k), 36'd1);
      end
    end
    step(1, 1, 1, 1);
    step(1, 0, 1, 0);
    checks++;
    if (obs(0) !== 36'd1) begin
      errors++;
      $display("[TB] FAIL reset_no_xfer got %h expected %h", obs(0), 36'd1);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 1'(i), 0, 0);
    checks++;
    if (b0.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_midword_busy got %b expected 1", b0.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    checks++;
    if (obs(0) !== 36'd1) begin
      errors++;
      $display("[TB] FAIL reset_midword got %h expected %h", obs(0), 36'd1);
    end
    step(0, 0, 0, 0);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [7:0] w;
    w = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      step(1, w[i], 0, 0);
      checks++;
      if (obs(0) !== expv(0)) begin
        errors++;
        $display("[TB] FAIL b2b_shift got %h expected %h", obs(0), expv(0));
      end
    end
    checks++;
    if (b0.d !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL b2b_d_at_e8 got %h expected a5", b0.d);
    end
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if ({b0.d, b0.c, b0.done} !== {8'hA5, (i == 1), (i == 3)} || obs(0) !== expv(0)) begin
        errors++;
        $display("[TB] FAIL b2b_seq E8+%0d got %h expected %h", i, obs(0), expv(0));
      end
    end
  endtask

  task automatic test_gapped;
    logic [7:0] w;
    w = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      step(0, 0, 0, 0);
      checks++;
      if (obs(0) !== expv(0)) begin
        errors++;
        $display("[TB] FAIL gap_idle got %h expected %h", obs(0), expv(0));
      end
      step(1, w[i], 0, 0);
    end
    checks++;
    if (b0.d !== 8'hA5 || b0.c !== 1'b0) begin
      errors++;
      $display("[TB] FAIL gap_e8 got d=%h c=%b expected d=a5 c=0", b0.d, b0.c);
    end
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if ({b0.d, b0.c, b0.done} !== {8'hA5, (i == 1), (i == 3)} || obs(0) !== expv(0)) begin
        errors++;
        $display("[TB] FAIL gap_seq E8+%0d got %h expected %h", i, obs(0), expv(0));
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] w, w2;
    int j;
    bit rdy;
    w  = 8'hA5;
    w2 = 8'($urandom);
    for (int i = 7; i >= 0; i--) step(1, w[i], 0, 0);
    j = 0;
    for (int n = 0; n < 40 && j < 8; n++) begin
      rdy = !in_window(0, t);
      step(1, w2[7 - j], 0, 0);
      if (rdy) j++;
      checks++;
      if (obs(0) !== expv(0) || (j < 8 && b0.d !== 8'hA5)) begin
        errors++;
        $display("[TB] FAIL backpressure n=%0d got %h expected %h", n, obs(0), expv(0));
      end
    end
    checks++;
    if (j != 8 || b0.d !== w2) begin
      errors++;
      $display("[TB] FAIL backpressure_word got %h expected %h (bits %0d)", b0.d, w2, j);
    end
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
  endtask

  task automatic test_reset_strobe;
    logic [7:0] w;
    int n;
    w = 8'($urandom) | 8'h01;
    for (int i = 7; i >= 0; i--) step(1, w[i], 0, 0);
    n = 0;
    while (b0.c !== 1'b1 && n < 20) begin
      step(0, 0, 0, 0);
      n++;
    end
    checks++;
    if (b0.c !== 1'b1) begin
      errors++;
      $display("[TB] FAIL strobe_timeout got c=%b expected 1", b0.c);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    checks++;
    if (b0.c !== 1'b0 || b0.d !== 8'h00 || b0.sin_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL strobe_reset got c=%b d=%h rdy=%b expected 0 00 1", b0.c, b0.d, b0.sin_ready);
    end
    step(0, 0, 0, 0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if (b0.c !== 1'b0 || obs(0) !== expv(0)) begin
        errors++;
        $display("[TB] FAIL strobe_after_reset got %h expected %h", obs(0), expv(0));
      end
    end
  endtask

  task automatic test_timing_sweep;
    logic [3:0] w;
    w = 4'h9;
    for (int i = 3; i >= 0; i--) step(0, 0, 1, w[i]);
    checks++;
    if (b1.d !== 4'h9 || b1.c !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sweep_e4 got d=%h c=%b expected 9 0", b1.d, b1.c);
    end
    for (int i = 1; i <= 9; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if ({b1.d, b1.c, b1.done} !== {4'h9, (i >= 2 && i < 5), (i == 7)} || obs(1) !== expv(1)) begin
        errors++;
        $display("[TB] FAIL sweep_seq E4+%0d got %h expected %h", i, obs(1), expv(1));
      end
    end
  endtask

  task automatic test_random;
    bit v0, s0, v1, s1;
    for (int n = 0; n < 400; n++) begin
      v0 = 1'($urandom_range(0, 1)); s0 = 1'($urandom);
      v1 = 1'($urandom_range(0, 1)); s1 = 1'($urandom);
      step(v0, s0, v1, s1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          errors++;
          $display("[TB] FAIL random dut%0d n=%0d got %h expected %h", k, n, obs(k), expv(k));
        end
      end
      if (n == 200) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        step(1, 1, 1, 1);
        #2 rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    b0.sin = 1'b0; b0.sin_valid = 1'b0;
    b1.sin = 1'b0; b1.sin_valid = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    test_reset;
    test_back_to_back;
    test_gapped;
    test_backpressure;
    test_reset_strobe;
    test_timing_sweep;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
